// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state and read-return owner tag.
package dmem_arbiter_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signal bundle around the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_lock;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters plus memory model side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter_rd_return_router.sv
// Remembers who won a read and steers the returning memory data back to it.
module rd_return_router
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              dma_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_rvalid_c,
  output logic [DATA_W-1:0] cpu_rdata_c,
  output logic              dma_rvalid_c,
  output logic [DATA_W-1:0] dma_rdata_c
);

  owner_e owner_q;
  owner_e owner_d;

  // Tag the winner of this cycle's read; at most one of cpu_rd/dma_rd is set.
  always_comb begin
    owner_d = OWN_NONE;
    if (cpu_rd) begin
      owner_d = OWN_CPU;
    end else if (dma_rd) begin
      owner_d = OWN_DMA;
    end
  end

  // Owner tag register; reset discards any read still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign cpu_rvalid_c = (owner_q == OWN_CPU);
  assign dma_rvalid_c = (owner_q == OWN_DMA);
  assign cpu_rdata_c  = cpu_rvalid_c ? mem_rdata : '0;
  assign dma_rdata_c  = dma_rvalid_c ? mem_rdata : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU and a DMA/debug port.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_e       state_q;
  arb_state_e       state_d;
  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             cpu_gnt_c;
  logic             dma_gnt_c;

  // State and starvation counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Grant decision and next state; a dropped DMA request releases the lock at once.
  always_comb begin
    state_d   = state_q;
    cpu_gnt_c = 1'b0;
    dma_gnt_c = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ARB: begin
          if (bus.cpu_req && !(bus.dma_req && (starve_q == STARVE_LIM))) begin
            cpu_gnt_c = 1'b1;
          end else if (bus.dma_req) begin
            dma_gnt_c = 1'b1;
          end
        end
        LOCKED: begin
          if (bus.dma_req) begin
            dma_gnt_c = 1'b1;
          end else begin
            state_d   = ARB;
            cpu_gnt_c = bus.cpu_req;
          end
        end
      endcase
      if (dma_gnt_c) begin
        state_d = bus.dma_lock ? LOCKED : ARB;
      end
    end
  end

  // Count consecutive DMA losses, saturating at the forcing threshold.
  always_comb begin
    starve_d = starve_q;
    if (!bus.dma_req || dma_gnt_c) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Steer the winner onto the memory port; idle drives zeros.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (cpu_gnt_c) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (dma_gnt_c) begin
      bus.mem_we    = bus.dma_we;
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
    end
  end

  assign bus.mem_en  = cpu_gnt_c | dma_gnt_c;
  assign bus.cpu_gnt = cpu_gnt_c;
  assign bus.dma_gnt = dma_gnt_c;

  rd_return_router #(
    .DATA_W(DATA_W)
  ) u_rd_return_router (
    .clk         (clk),
    .reset       (reset),
    .cpu_rd      (cpu_gnt_c & ~bus.cpu_we),
    .dma_rd      (dma_gnt_c & ~bus.dma_we),
    .mem_rdata   (bus.mem_rdata),
    .cpu_rvalid_c(bus.cpu_rvalid),
    .cpu_rdata_c (bus.cpu_rdata),
    .dma_rvalid_c(bus.dma_rvalid),
    .dma_rdata_c (bus.dma_rdata)
  );

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the core's load/store path and a DMA/debug requester. It grants at most one access per cycle, steers address, write data and write enable to the memory, and returns read data to the winner one cycle later. Fixed CPU priority is bounded by a starvation counter, and a lock lets DMA hold the memory for atomic bursts. It sits between the core datapath/DMA engine and the data memory.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive DMA losses before DMA is forced to win (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_rvalid  out  1  CPU load data valid
- cpu_rdata  out  DATA_W  CPU load data
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  same meaning for DMA
- dma_lock  in  1  keep ownership after this DMA access
- dma_gnt, dma_rvalid, dma_rdata  out  1/1/DATA_W  same meaning for DMA
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe

## Operation
- Handshake: a transfer occurs in a cycle where req && gnt. A requester keeps req, we, addr and wdata stable until gnt. cpu_gnt and dma_gnt are never both 1.
- FSM states: ARB and LOCKED.
- In ARB:
  - CPU wins by default.
  - DMA wins if cpu_req=0, or if starve_cnt == STARVE_MAX.
  - A DMA grant with dma_lock=1 moves the FSM to LOCKED.
- In LOCKED:
  - Only DMA can be granted; cpu_gnt=0.
  - The FSM returns to ARB on a DMA grant with dma_lock=0, or when dma_req=0.
- starve_cnt: saturating counter, width clog2(STARVE_MAX+1).
  - Increments when dma_req && !dma_gnt.
  - Clears on dma_gnt or on dma_req=0.
- Memory side:
  - mem_en = cpu_gnt | dma_gnt.
  - mem_we, mem_addr and mem_wdata are the winner's signals; mem_en=0 forces mem_we=0.
  - When idle, mem_addr and mem_wdata hold 0.
- Read return:
  - A registered owner tag records the winner of a granted read (we=0).
  - The next cycle, that owner's rvalid=1 and its rdata=mem_rdata.
  - The other requester's rdata is 0.
  - Writes produce no rvalid.

## Timing
- Grant and memory signals are combinational from req, state and starve_cnt; there is no request-to-memory latency.
- Read latency: rvalid arrives exactly 1 cycle after the granting cycle. Back-to-back reads return on consecutive cycles with correct owners.
- Reset:
  - While reset=1, all gnt, rvalid and mem_en are 0, and rdata and mem_* are 0.
  - The FSM is forced to ARB, starve_cnt=0 and the owner tag is cleared.
  - Reset asserted mid-lock or with a read pending drops the lock and the pending rvalid; no response appears after reset releases.
- Simultaneous events:
  - Both requesting with starve_cnt < STARVE_MAX: CPU wins.
  - At STARVE_MAX: DMA wins and the counter clears the next cycle.
  - dma_req dropping while LOCKED: return to ARB in the same cycle, so the CPU may be granted that cycle.

## Structure
- A shared package holds the FSM state enum (ARB, LOCKED) and the owner enum (NONE, CPU, DMA).
- A sub-module `rd_return_router` is natural: it contains the owner-tag register and the rvalid/rdata demux. All other logic stays in the top.

## Test plan
- CPU only: cpu_req, load from 0x10 with memory returning 0xDEADBEEF -> cpu_gnt same cycle, mem_addr=0x10, cpu_rvalid=1 with cpu_rdata=0xDEADBEEF the next cycle, dma_rvalid=0.
- Contention with STARVE_MAX=4 and both requesting continuously -> CPU granted 4 cycles, DMA granted on the 5th, pattern repeats; never two grants in one cycle.
- Lock burst: DMA issues 3 writes with dma_lock=1,1,0 while cpu_req=1 -> 3 consecutive dma_gnt, cpu_gnt=0 throughout, CPU granted the cycle after the third.
- Interleaved reads: CPU read 0x4, then DMA read 0x8 on the next cycle -> cpu_rvalid then dma_rvalid on consecutive cycles, each with its own data.
- Reset mid-operation: assert reset in LOCKED with a read pending -> all outputs 0 immediately, no stale rvalid after release, first CPU request granted.
- Store: cpu_we=1, addr 0x20, data 0x5A -> mem_en=1, mem_we=1, mem_wdata=0x5A, no rvalid the following cycle.
